// File: rtl/param_loader_multi.sv
// Multi-beat coefficient loader: assembles NUM_COEF coefficients from a narrow pin bus,
// commits them atomically to shadow outputs and runs a start/busy handshake with the core.
module param_loader_multi #(
  parameter int unsigned NUM_COEF    = 2,
  parameter int unsigned PIN_W       = 8,
  parameter int unsigned BEATS       = 2,
  parameter int unsigned COEF_W      = 32,
  parameter int unsigned SIGNED_MODE = 1,
  parameter int unsigned ACK_TO      = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PIN_W-1:0]           pin_data,
  input  logic                       pin_valid,
  input  logic                       abort,
  input  logic                       core_busy,
  output logic [NUM_COEF*COEF_W-1:0] coef_flat,
  output logic                       start_calc,
  output logic                       loading,
  output logic                       err_drop,
  output logic                       err_timeout
);

  localparam int unsigned ASM_W  = BEATS * PIN_W;
  localparam int unsigned BCNT_W = $clog2(BEATS + 1);
  localparam int unsigned IDX_W  = (NUM_COEF > 1) ? $clog2(NUM_COEF) : 1;
  localparam int unsigned TO_W   = $clog2(ACK_TO + 1);
  localparam int unsigned FLAT_W = NUM_COEF * COEF_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_START = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ASM_W-1:0]    asm_q, asm_d;
  logic [BCNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [IDX_W-1:0]    coef_idx_q, coef_idx_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [COEF_W-1:0]   stage_q [NUM_COEF];
  logic [COEF_W-1:0]   stage_d [NUM_COEF];
  logic [FLAT_W-1:0]   coef_q, coef_d;
  logic                start_q, start_d;
  logic                loading_q, loading_d;
  logic                err_drop_q, err_drop_d;
  logic                err_to_q, err_to_d;

  // Beat assembly helpers; a frame in S_IDLE always starts from an empty register and slot 0.
  logic [ASM_W-1:0]         asm_base;
  logic [ASM_W-1:0]         asm_shift;
  logic signed [ASM_W-1:0]  asm_signed;
  logic signed [COEF_W-1:0] ext_signed;
  logic [COEF_W-1:0]        coef_ext;
  logic [BCNT_W-1:0]        beat_next;
  logic [IDX_W-1:0]         idx_cur;

  always_comb begin
    asm_base   = (state_q == S_IDLE) ? '0 : asm_q;
    asm_shift  = ASM_W'({asm_base, pin_data});
    asm_signed = asm_shift;
    ext_signed = asm_signed;
    coef_ext   = (SIGNED_MODE != 0) ? COEF_W'(ext_signed) : COEF_W'(asm_shift);
    beat_next  = BCNT_W'(((state_q == S_IDLE) ? '0 : beat_cnt_q) + 1'b1);
    idx_cur    = (state_q == S_IDLE) ? '0 : coef_idx_q;
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    asm_d      = asm_q;
    beat_cnt_d = beat_cnt_q;
    coef_idx_d = coef_idx_q;
    to_cnt_d   = to_cnt_q;
    stage_d    = stage_q;
    coef_d     = coef_q;
    err_drop_d = err_drop_q;
    err_to_d   = err_to_q;

    if (abort) begin
      state_d    = S_IDLE;
      asm_d      = '0;
      beat_cnt_d = '0;
      coef_idx_d = '0;
      to_cnt_d   = '0;
      err_drop_d = 1'b0;
      err_to_d   = 1'b0;
      for (int i = 0; i < int'(NUM_COEF); i++) stage_d[i] = '0;
    end else begin
      case (state_q)
        S_IDLE, S_LOAD: begin
          if (pin_valid) begin
            state_d    = S_LOAD;
            asm_d      = asm_shift;
            beat_cnt_d = beat_next;
            coef_idx_d = idx_cur;
            if (beat_next == BCNT_W'(BEATS)) begin
              asm_d            = '0;
              beat_cnt_d       = '0;
              stage_d[idx_cur] = coef_ext;
              if (idx_cur == IDX_W'(NUM_COEF - 1)) begin
                // Final beat of the frame: publish every slot in one edge.
                for (int i = 0; i < int'(NUM_COEF); i++) begin
                  coef_d[i*COEF_W +: COEF_W] = (IDX_W'(i) == idx_cur) ? coef_ext : stage_q[i];
                end
                coef_idx_d = '0;
                to_cnt_d   = '0;
                state_d    = S_START;
              end else begin
                coef_idx_d = IDX_W'(idx_cur + 1'b1);
              end
            end
          end
        end
        S_START: begin
          if (pin_valid) err_drop_d = 1'b1;
          if (core_busy) begin
            state_d = S_RUN;
          end else if (to_cnt_q == TO_W'(ACK_TO - 1)) begin
            err_to_d = 1'b1;
            state_d  = S_IDLE;
          end else begin
            to_cnt_d = TO_W'(to_cnt_q + 1'b1);
          end
        end
        S_RUN: begin
          if (pin_valid) err_drop_d = 1'b1;
          if (!core_busy) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    start_d   = (state_d == S_START);
    loading_d = (state_d == S_LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      asm_q      <= '0;
      beat_cnt_q <= '0;
      coef_idx_q <= '0;
      to_cnt_q   <= '0;
      coef_q     <= '0;
      start_q    <= 1'b0;
      loading_q  <= 1'b0;
      err_drop_q <= 1'b0;
      err_to_q   <= 1'b0;
      for (int i = 0; i < int'(NUM_COEF); i++) stage_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      asm_q      <= asm_d;
      beat_cnt_q <= beat_cnt_d;
      coef_idx_q <= coef_idx_d;
      to_cnt_q   <= to_cnt_d;
      coef_q     <= coef_d;
      start_q    <= start_d;
      loading_q  <= loading_d;
      err_drop_q <= err_drop_d;
      err_to_q   <= err_to_d;
      stage_q    <= stage_d;
    end
  end

  assign coef_flat   = coef_q;
  assign start_calc  = start_q;
  assign loading     = loading_q;
  assign err_drop    = err_drop_q;
  assign err_timeout = err_to_q;

endmodule
